// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and transmitter.
//   uart_rx_state_t           receiver FSM state encoding
//   UART_DATA_BITS            data bits per frame
//   UART_CLKS_PER_BIT_DEFAULT default bit period in clk cycles
//   uart_half_bit()           mid-bit offset used to validate the start bit
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_t;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 87;

    function automatic int uart_half_bit(input int clks);
        return clks / 2;
    endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: valid/ready byte stream out of the UART receiver.
//   m_data   received byte (LSB = first data bit on the line)
//   m_valid  m_data holds an unconsumed byte
//   m_ready  consumer accepts m_data when m_valid && m_ready
//   master modport: the receiver; slave modport: the consumer.
interface uart_byte_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] m_data;
    logic                      m_valid;
    logic                      m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/uart_line_sync.sv
// uart_line_sync: multi-flop synchroniser for an asynchronous serial line.
//   clk  sampling clock
//   rst  synchronous active-high reset; all stages preset to 1 (line idle)
//   d    asynchronous input
//   q    synchronised output, SYNC_STAGES cycles of latency
module uart_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '1;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with a single-entry valid/ready output.
// Optional 8E1 framing when the macro UART_RX_PARITY_EN is defined.
//   clk         single clock, posedge
//   rst         synchronous reset, active-high
//   uart_tx_in  asynchronous serial line, idle high
//   stream      uart_byte_rx_if.master: m_data / m_valid / m_ready
//   busy        frame in progress (state != IDLE)
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: byte completed while holding register full
//   parity_err  one-cycle pulse: even-parity mismatch (0 without UART_RX_PARITY_EN)
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_tx_in,
    uart_byte_rx_if.master        stream,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  parity_err
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF = 8'(uart_half_bit(CLKS_PER_BIT));

    logic rxs;

    uart_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_tx_in),
        .q   (rxs)
    );

    uart_rx_state_t            state, state_nxt;
    logic [7:0]                bit_cnt, cnt_nxt;
    logic [2:0]                bit_idx, idx_nxt;
    logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
    logic [UART_DATA_BITS-1:0] hold_data;
    logic                      hold_valid;
    logic                      deliver, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic                      par_bit, par_nxt, perr_set;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt + 8'd1;
        idx_nxt   = bit_idx;
        shreg_nxt = shreg;
        deliver   = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_bit;
        perr_set  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxs) state_nxt = START;
            end
            START: begin
                if (bit_cnt == HALF) begin
                    state_nxt = rxs ? IDLE : DATA;
                    idx_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_cnt == LAST) begin
                    cnt_nxt   = '0;
                    shreg_nxt = {rxs, shreg[UART_DATA_BITS-1:1]};
                    idx_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_cnt == LAST) begin
                    par_nxt   = rxs;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_cnt == LAST) begin
`ifdef UART_RX_PARITY_EN
                    perr_set = (par_bit != ^shreg);
                    deliver  = rxs && !perr_set;
`else
                    deliver  = rxs;
`endif
                    ferr_set  = !rxs;
                    state_nxt = rxs ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // The timer restarts on every state change and never runs while idle.
        if (state_nxt != state || state == IDLE || state == BREAK) cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            bit_cnt   <= cnt_nxt;
            bit_idx   <= idx_nxt;
            shreg     <= shreg_nxt;
            frame_err <= ferr_set;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_nxt;
            parity_err <= perr_set;
`endif
            // A delivery coinciding with a handshake reloads the register
            // instead of dropping m_valid.
            if (deliver) begin
                if (hold_valid && !stream.m_ready) begin
                    overrun <= 1'b1;
                end else begin
                    hold_data  <= shreg;
                    hold_valid <= 1'b1;
                end
            end else if (hold_valid && stream.m_ready) begin
                hold_valid <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    assign busy           = (state != IDLE);
    assign stream.m_data  = hold_data;
    assign stream.m_valid = hold_valid;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed bench for uart_byte_rx with a byte scoreboard.
// Define UART_RX_PARITY_EN for both bench and RTL to exercise 8E1 framing.
module tb_uart_byte_rx;

    localparam int CPB = 87;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic line = 1'b1;
    logic busy, frame_err, overrun, parity_err;

    uart_byte_rx_if stream_if ();

    uart_byte_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_tx_in (line),
        .stream     (stream_if),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         hs_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
    bit         busy_seen = 1'b0;
    int         h0, f0, o0, p0;
`ifdef UART_RX_PARITY_EN
    bit         flip_parity = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after posedge; monitor samples on negedge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic snap();
        h0 = hs_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        line = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        line = (^b) ^ flip_parity;
        tick(CPB);
`endif
        line = stop_bit;
        tick(CPB);
    endtask

    always @(negedge clk) begin
        if (busy)       busy_seen = 1'b1;
        if (frame_err)  ferr_cnt++;
        if (overrun)    ovr_cnt++;
        if (parity_err) perr_cnt++;
        if (stream_if.m_valid && stream_if.m_ready) begin
            hs_cnt++;
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_byte: observed %02h expected none", stream_if.m_data);
            end
            if (exp_q.size() != 0) check("rx_data", {24'b0, stream_if.m_data}, {24'b0, exp_q.pop_front()});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stream_if.m_ready = 1'b1;
        tick(3);
        check("rst_m_valid", {31'b0, stream_if.m_valid}, 32'd0);
        check("rst_m_data", {24'b0, stream_if.m_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        check("rst_parity_err", {31'b0, parity_err}, 32'd0);
        rst = 1'b0;
        tick(5);

        // Plain byte with consumer ready
        snap();
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        tick(2 * CPB);
        check("t55_handshakes", hs_cnt - h0, 1);
        check("t55_frame_err", ferr_cnt - f0, 0);
        check("t55_overrun", ovr_cnt - o0, 0);

        // Glitch shorter than half a bit: false start
        snap();
        busy_seen = 1'b0;
        line = 1'b0;
        tick(20);
        line = 1'b1;
        tick(2 * CPB);
        check("glitch_busy_seen", {31'b0, busy_seen}, 32'd1);
        check("glitch_handshakes", hs_cnt - h0, 0);
        check("glitch_frame_err", ferr_cnt - f0, 0);
        check("glitch_idle", {31'b0, busy}, 32'd0);

        // Bad stop bit followed by a long break, then recovery
        snap();
        send_frame(8'hA3, 1'b0);
        tick(300);
        line = 1'b1;
        tick(CPB);
        check("break_frame_err", ferr_cnt - f0, 1);
        check("break_handshakes", hs_cnt - h0, 0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        tick(2 * CPB);
        check("recover_handshakes", hs_cnt - h0, 1);

        // Overrun: consumer stalled across two frames
        snap();
        stream_if.m_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(2 * CPB);
        check("ovr_m_valid", {31'b0, stream_if.m_valid}, 32'd1);
        check("ovr_m_data", {24'b0, stream_if.m_data}, 32'h11);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_no_handshake", hs_cnt - h0, 0);
        stream_if.m_ready = 1'b1;
        tick(3);
        check("ovr_drain_handshakes", hs_cnt - h0, 1);
        check("ovr_drain_m_valid", {31'b0, stream_if.m_valid}, 32'd0);

        // Reset after data bit 3 of 0xFF
        snap();
        line = 1'b0;
        tick(CPB);
        line = 1'b1;
        tick(4 * CPB);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_m_valid", {31'b0, stream_if.m_valid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        tick(6 * CPB);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        tick(2 * CPB);
        check("midrst_handshakes", hs_cnt - h0, 1);

`ifdef UART_RX_PARITY_EN
        // Even parity: bad parity bit drops the byte, good one delivers it
        snap();
        flip_parity = 1'b1;
        send_frame(8'h07, 1'b1);
        tick(2 * CPB);
        check("par_bad_pulse", perr_cnt - p0, 1);
        check("par_bad_handshakes", hs_cnt - h0, 0);
        snap();
        flip_parity = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        tick(2 * CPB);
        check("par_good_pulse", perr_cnt - p0, 0);
        check("par_good_handshakes", hs_cnt - h0, 1);
`else
        check("noparity_parity_err_pulses", perr_cnt, 0);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
